mem_fifo_ctrl: RTL and testbench
================================

// Module: mem_fifo_ctrl
// PURPOSE
//  Sequencer that sits directly upstream of the 16x8 level-sensitive memory (read/write/addr/data_in -> data_out)
//  and turns it into a clocked FIFO. Producer side uses valid/ready; consumer side uses valid/ready with a one-entry
//  output register. Drives the memory one operation per cycle: either a write strobe or a read strobe.
// PARAMETERS
//  DW     8   data width; matches memory data_in/data_out
//  AW     4   address width; memory depth DEPTH = 2**AW = 16
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      producer has in_data
//  in_ready   out  1      controller accepts in_data this cycle
//  in_data    in   DW     write data
//  out_valid  out  1      out_data holds a FIFO entry
//  out_ready  in   1      consumer takes out_data this cycle
//  out_data   out  DW     head-of-FIFO data (registered)
//  mem_read   out  1      to memory read; registered
//  mem_write  out  1      to memory write; registered
//  mem_addr   out  AW     to memory addr; registered
//  mem_wdata  out  DW     to memory data_in; registered
//  mem_rdata  in   DW     from memory data_out (combinational while mem_read=1)
//  count      out  AW+1   entries held in memory (excludes output register), 0..16
//  full       out  1      count == DEPTH
//  empty      out  1      count == 0 && !out_valid
// BEHAVIOUR
//  - Reset: state=IDLE, wr_ptr=rd_ptr=0, count=0. All mem_* outputs, out_valid and out_data are 0.
//    Memory contents are not cleared. Reset applies immediately mid-operation; a pending WR/RD is dropped.
//  - FSM: IDLE, WR, RD. mem_write=1 only in WR; mem_read=1 only in RD. Both are never high together.
//  - IDLE, read priority: if count!=0 && !out_valid -> RD. Load mem_addr=rd_ptr. in_ready=0.
//  - IDLE, otherwise: in_ready = !full. On in_valid&&in_ready -> WR. Load mem_addr=wr_ptr, mem_wdata=in_data.
//  - IDLE with neither condition: stay IDLE; mem_read=mem_write=0.
//  - WR (1 cycle): mem_write=1 with stable addr/data. At exit: wr_ptr++, count++, return to IDLE.
//  - RD (1 cycle): mem_read=1. At exit: out_data<=mem_rdata, out_valid<=1, rd_ptr++, count--, return to IDLE.
//  - in_ready=0 in WR and RD. Throughput is 1 entry per 2 cycles.
//  - Write latency: accepted in cycle N -> mem_write=1 in N+1 -> count updated from N+2.
//  - Read-out latency: IDLE sees count>0 in cycle M -> mem_read=1 in M+1 -> out_valid=1 from M+2.
//  - Output register: out_valid clears on out_valid&&out_ready unless an RD completes in the same cycle
//    (not reachable, since RD requires !out_valid). out_data is held stable while out_valid&&!out_ready.
//  - Pointers are AW bits and wrap 15->0 naturally. count saturates by construction:
//    no write when full, no read when 0.
//  - Capacity: 16 in memory + 1 in output register = 17 entries. FIFO order is strictly preserved.
//  - mem_read/mem_write are registered, so the memory never sees a combinational glitch on its strobes.
// TESTING
//  1 Reset -> all outputs 0, empty=1, in_ready=1 in first IDLE cycle; assert reset mid-WR -> mem_write falls
//    asynchronously, count=0.
//  2 Single push 8'hA5, out_ready=1 -> WR cycle with mem_addr=0 and mem_wdata=A5, then RD with mem_addr=0,
//    then out_valid=1 with out_data=A5 for 1 cycle; then empty=1.
//  3 out_ready=0, push 17 values 0x00..0x10 -> out_data=0x00 held, count=16, full=1, in_ready=0.
//    The 18th push stalls, with no mem_write.
//  4 Drain case 3 with out_ready=1 -> out_data sequence 0x00..0x10 in order, then empty=1, count=0.
//  5 Stream 40 $random bytes with random in_valid/out_ready -> scoreboard matches in order; wr_ptr and rd_ptr
//    each wrap 15->0 at least twice.
//  6 count>0, out slot empty, in_valid=1 in the same IDLE cycle -> RD is taken first (in_ready=0);
//    the write is accepted in the next IDLE cycle.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// Clocked FIFO sequencer in front of a level-sensitive 16x8 memory, with a one-entry output register.
// Latency: push -> mem_write next cycle; a pending entry reaches out_valid two cycles after IDLE sees it; producer backpressured by in_ready.
module mem_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic w_full;
    logic w_rd_go;
    logic w_wr_go;

    // Refilling the output register wins over accepting a new push.
    assign w_full   = (r_count == (AW + 1)'(DEPTH));
    assign w_rd_go  = (r_state == IDLE) && (r_count != '0) && !r_out_valid;
    assign in_ready = (r_state == IDLE) && !w_rd_go && !w_full;
    assign w_wr_go  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_rd_go) begin
                        r_state    <= RD;
                        r_mem_read <= 1'b1;
                        r_mem_addr <= r_rd_ptr;
                    end else if (w_wr_go) begin
                        r_state     <= WR;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= r_wr_ptr;
                        r_mem_wdata <= in_data;
                    end
                end
                WR: begin
                    r_state     <= IDLE;
                    r_mem_write <= 1'b0;
                    r_wr_ptr    <= r_wr_ptr + AW'(1);
                    r_count     <= r_count + (AW + 1)'(1);
                end
                RD: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_out_data  <= mem_rdata;
                    r_out_valid <= 1'b1;
                    r_rd_ptr    <= r_rd_ptr + AW'(1);
                    r_count     <= r_count - (AW + 1)'(1);
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = (r_count == '0) && !r_out_valid;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: behavioural 16x8 memory, scoreboard queue filled on accepted pushes, drained on consumer handshakes.
module tb_mem_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int wr_wraps = 0;
    int rd_wraps = 0;
    logic count_wraps = 1'b0;
    logic [7:0] sb_q[$];
    logic [7:0] mem [16];

    mem_fifo_ctrl #(.DW(8), .AW(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: inputs and outputs are settled at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) sb_q.push_back(in_data);
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb_q.size() == 0) chk("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
                else chk("out_data_order", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
            end
            if (count_wraps && mem_write && mem_addr == 4'hF) wr_wraps++;
            if (count_wraps && mem_read && mem_addr == 4'hF) rd_wraps++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (!(empty && sb_q.size() == 0) && k < limit) begin
            step();
            k++;
        end
        if (k >= limit) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        bit saw_wr;
        bit prod_done;
        // Reset state
        #3;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        step();
        reset = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Reset asserted in the middle of a WR cycle
        in_valid = 1'b1;
        in_data  = 8'h33;
        step();
        in_valid = 1'b0;
        chk("wr_before_rst", mem_write, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_wr_rst_mem_write", mem_write, 0);
        chk("mid_wr_rst_count", count, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Single push through to the consumer
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("t2_wr_strobe", mem_write, 1);
        chk("t2_wr_read", mem_read, 0);
        chk("t2_wr_addr", mem_addr, 0);
        chk("t2_wr_data", mem_wdata, 8'hA5);
        step();
        chk("t2_count", count, 1);
        step();
        chk("t2_rd_strobe", mem_read, 1);
        chk("t2_rd_write", mem_write, 0);
        chk("t2_rd_addr", mem_addr, 0);
        step();
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 8'hA5);
        step();
        chk("t2_out_cleared", out_valid, 0);
        chk("t2_empty", empty, 1);

        // Fill to capacity with consumer stalled
        out_ready = 1'b0;
        n_pop = 0;
        for (int v = 0; v < 17; v++) push(8'(v));
        step();
        step();
        chk("t3_count", count, 16);
        chk("t3_full", full, 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_out_data_held", out_data, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'h11;
        saw_wr = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mem_write || in_ready) saw_wr = 1;
            step();
        end
        in_valid = 1'b0;
        chk("t3_stall_no_write", saw_wr, 0);
        chk("t3_out_data_still", out_data, 8'h00);

        // Drain in order
        out_ready = 1'b1;
        wait_drain(300);
        chk("t4_pop_count", n_pop, 17);
        chk("t4_empty", empty, 1);
        chk("t4_count", count, 0);

        // Random stream with random backpressure
        count_wraps = 1'b1;
        n_pop = 0;
        prod_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    push(8'($urandom_range(0, 255)));
                end
                prod_done = 1;
            end
            begin
                int k = 0;
                while (!(prod_done && empty && sb_q.size() == 0) && k < 2000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                    k++;
                end
                if (k >= 2000) chk("t5_timeout", 0, 1);
            end
        join
        count_wraps = 1'b0;
        chk("t5_pop_count", n_pop, 40);
        chk("t5_wr_wraps", (wr_wraps >= 2), 1);
        chk("t5_rd_wraps", (rd_wraps >= 2), 1);

        // Read takes priority over a simultaneous push
        out_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        step();
        step();
        chk("t6_setup_count", count, 1);
        chk("t6_setup_out_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB3;
        #1;
        chk("t6_in_ready_blocked", in_ready, 0);
        step();
        chk("t6_rd_first", mem_read, 1);
        chk("t6_no_wr", mem_write, 0);
        chk("t6_in_ready_rd", in_ready, 0);
        step();
        chk("t6_in_ready_next", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t6_wr_after", mem_write, 1);
        chk("t6_wr_data", mem_wdata, 8'hB3);
        out_ready = 1'b1;
        wait_drain(100);
        chk("t6_queue_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
